ysram_owner_sched: RTL

Sequential owner scheduler for the Y SRAM bus. It arbitrates between the Y compute module (control path) and the Y write module (write path), and drives the one-hot module-enable pair that selects which path's addresses, write enable and write data reach the Y SRAM through the bus multiplexer. It adds four things the bare multiplexer lacks:
- a request/grant handshake,
- round-robin fairness,
- a forced turnaround bubble between owners,
- a hold-time limit that asks a long-running owner to yield.

---
 rtl/ysram_sched_pkg.sv | 24 ++
 rtl/ysram_hold_timer.sv | 46 ++++
 rtl/ysram_owner_sched.sv | 109 ++++++++++
 3 files changed

// File: rtl/ysram_sched_pkg.sv
// ---------------------------------------------------------------------------
// ysram_sched_pkg: shared types and helpers for the Y SRAM owner scheduler
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ysram_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_C = 2'd1,
    OWN_W = 2'd2,
    TURN  = 2'd3
  } sched_state_e;

  localparam int MAX_HOLD_DEFAULT = 64;

  function automatic int hold_cnt_width(input int max_hold);
    return $clog2(max_hold + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ysram_hold_timer.sv
// ---------------------------------------------------------------------------
// ysram_hold_timer: clearable saturating hold counter with a full flag
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ysram_hold_timer
  import ysram_sched_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT,
  parameter int CNT_W    = hold_cnt_width(MAX_HOLD)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic full_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_HOLD);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != MAX_CNT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign full_o = (cnt_q == MAX_CNT);

endmodule

`default_nettype wire

// File: rtl/ysram_owner_sched.sv
// ---------------------------------------------------------------------------
// ysram_owner_sched: round-robin owner scheduler for the Y SRAM bus mux
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ysram_owner_sched
  import ysram_sched_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic in_computeReq,
  input  logic in_writeReq,
  output logic op_yComputeModuleEnable,
  output logic op_yWriteModuleEnable,
  output logic op_computeGrant,
  output logic op_writeGrant,
  output logic op_yieldReq,
  output logic op_busy
);

  sched_state_e state_q;
  sched_state_e state_d;
  logic         lastw_q;
  logic         lastw_d;
  logic         cen_q;
  logic         wen_q;
  logic         yield_q;
  logic         yield_d;
  logic         busy_q;
  logic         hold_full;
  logic         owning;

  assign owning = (state_q == OWN_C) || (state_q == OWN_W);

  // Counter sits at zero outside ownership, so it is zero on every entry.
  ysram_hold_timer #(
    .MAX_HOLD (MAX_HOLD)
  ) u_hold_timer (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (!owning),
    .en_i   (owning),
    .full_o (hold_full)
  );

  always_comb begin
    state_d = state_q;
    lastw_d = lastw_q;
    unique case (state_q)
      IDLE: begin
        if (in_computeReq && in_writeReq) begin
          state_d = lastw_q ? OWN_C : OWN_W;
        end else if (in_computeReq) begin
          state_d = OWN_C;
        end else if (in_writeReq) begin
          state_d = OWN_W;
        end
      end
      OWN_C: begin
        if (!in_computeReq) begin
          state_d = TURN;
          lastw_d = 1'b0;
        end
      end
      OWN_W: begin
        if (!in_writeReq) begin
          state_d = TURN;
          lastw_d = 1'b1;
        end
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With both requests high the owner is staying and the other side waits.
  assign yield_d = owning && hold_full && in_computeReq && in_writeReq;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lastw_q <= 1'b1;
      cen_q   <= 1'b0;
      wen_q   <= 1'b0;
      yield_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lastw_q <= lastw_d;
      cen_q   <= (state_d == OWN_C);
      wen_q   <= (state_d == OWN_W);
      yield_q <= yield_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign op_yComputeModuleEnable = cen_q;
  assign op_yWriteModuleEnable   = wen_q;
  assign op_computeGrant         = cen_q;
  assign op_writeGrant           = wen_q;
  assign op_yieldReq             = yield_q;
  assign op_busy                 = busy_q;

endmodule

`default_nettype wire
